// File: rtl/reindeer_csr_access_seq.sv
// Zicsr execute-stage sequencer: issues the read and write accesses to the CSR port
// one at a time, does the read-modify-write arithmetic, and returns the old value for rd.
module reindeer_csr_access_seq #(
    parameter int XLEN          = 32,
    parameter int CSR_ADDR_BITS = 12,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     start,
    input  logic [2:0]               funct3,
    input  logic [CSR_ADDR_BITS-1:0] csr_addr,
    input  logic [REG_ADDR_BITS-1:0] rs1_idx,
    input  logic [XLEN-1:0]          rs1_data,
    input  logic [REG_ADDR_BITS-1:0] rd_idx,
    input  logic                     abort,
    output logic                     csr_read_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_read_addr,
    input  logic                     csr_read_valid,
    input  logic [XLEN-1:0]          csr_read_data,
    output logic                     csr_write_enable,
    output logic [CSR_ADDR_BITS-1:0] csr_write_addr,
    output logic [XLEN-1:0]          csr_write_data,
    input  logic                     csr_fault,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal,
    output logic                     rd_we,
    output logic [REG_ADDR_BITS-1:0] rd_addr,
    output logic [XLEN-1:0]          rd_data
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, WWAIT, FIN} state_t;

    state_t                   state;
    logic [1:0]               op_q;
    logic [CSR_ADDR_BITS-1:0] addr_q;
    logic [XLEN-1:0]          src_q;
    logic [XLEN-1:0]          old_q;
    logic [REG_ADDR_BITS-1:0] rd_idx_q;
    logic                     need_read_q;
    logic                     need_write_q;

    logic [XLEN-1:0] start_src;
    logic            start_need_read;
    logic            start_need_write;
    logic            start_illegal;
    logic            rwait_fault;
    logic [XLEN-1:0] rmw_new;

    function automatic logic [XLEN-1:0] rmw(input logic [1:0] op, input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] src);
        case (op)
            2'b10:   rmw = old | src;
            2'b11:   rmw = old & ~src;
            default: rmw = src;
        endcase
    endfunction

    // Start-time decode; only steers the next state, never an output directly.
    assign start_src        = funct3[2] ? {{(XLEN-REG_ADDR_BITS){1'b0}}, rs1_idx} : rs1_data;
    assign start_need_read  = !(funct3[1:0] == 2'b01 && rd_idx == '0);
    assign start_need_write = (funct3[1:0] == 2'b01) || (rs1_idx != '0);
    assign start_illegal    = (funct3[1:0] == 2'b00) ||
                              (start_need_write && csr_addr[CSR_ADDR_BITS-1 -: 2] == 2'b11);
    assign rwait_fault      = csr_fault || !csr_read_valid;
    assign rmw_new          = rmw(op_q, csr_read_data, src_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            op_q             <= '0;
            addr_q           <= '0;
            src_q            <= '0;
            old_q            <= '0;
            rd_idx_q         <= '0;
            need_read_q      <= 1'b0;
            need_write_q     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            illegal          <= 1'b0;
            rd_we            <= 1'b0;
            rd_addr          <= '0;
            rd_data          <= '0;
            csr_read_enable  <= 1'b0;
            csr_read_addr    <= '0;
            csr_write_enable <= 1'b0;
            csr_write_addr   <= '0;
            csr_write_data   <= '0;
        end else if (sync_reset) begin
            state            <= IDLE;
            op_q             <= '0;
            addr_q           <= '0;
            src_q            <= '0;
            old_q            <= '0;
            rd_idx_q         <= '0;
            need_read_q      <= 1'b0;
            need_write_q     <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            illegal          <= 1'b0;
            rd_we            <= 1'b0;
            rd_addr          <= '0;
            rd_data          <= '0;
            csr_read_enable  <= 1'b0;
            csr_read_addr    <= '0;
            csr_write_enable <= 1'b0;
            csr_write_addr   <= '0;
            csr_write_data   <= '0;
        end else begin
            // Strobes and completion flags are single-cycle; rd_data/rd_addr hold.
            csr_read_enable  <= 1'b0;
            csr_write_enable <= 1'b0;
            done             <= 1'b0;
            illegal          <= 1'b0;
            rd_we            <= 1'b0;

            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            op_q         <= funct3[1:0];
                            addr_q       <= csr_addr;
                            src_q        <= start_src;
                            old_q        <= '0;
                            rd_idx_q     <= rd_idx;
                            need_read_q  <= start_need_read;
                            need_write_q <= start_need_write;
                            busy         <= 1'b1;
                            if (start_illegal) begin
                                state   <= FIN;
                                done    <= 1'b1;
                                illegal <= 1'b1;
                                rd_addr <= rd_idx;
                                rd_data <= '0;
                            end else if (start_need_read) begin
                                state           <= RD;
                                csr_read_enable <= 1'b1;
                                csr_read_addr   <= csr_addr;
                            end else begin
                                state            <= WR;
                                csr_write_enable <= 1'b1;
                                csr_write_addr   <= csr_addr;
                                csr_write_data   <= start_src;
                            end
                        end
                    end
                    RD: state <= RWAIT;
                    RWAIT: begin
                        if (rwait_fault) begin
                            state   <= FIN;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            rd_addr <= rd_idx_q;
                            rd_data <= old_q;
                        end else begin
                            old_q <= csr_read_data;
                            if (need_write_q) begin
                                state            <= WR;
                                csr_write_enable <= 1'b1;
                                csr_write_addr   <= addr_q;
                                csr_write_data   <= rmw_new;
                            end else begin
                                state   <= FIN;
                                done    <= 1'b1;
                                rd_we   <= (rd_idx_q != '0);
                                rd_addr <= rd_idx_q;
                                rd_data <= csr_read_data;
                            end
                        end
                    end
                    WR: state <= WWAIT;
                    WWAIT: begin
                        state   <= FIN;
                        done    <= 1'b1;
                        illegal <= csr_fault;
                        rd_we   <= !csr_fault && need_read_q && (rd_idx_q != '0);
                        rd_addr <= rd_idx_q;
                        rd_data <= old_q;
                    end
                    FIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reindeer_csr_access_seq.sv
// Randomized bench for reindeer_csr_access_seq: a behavioural CSR block responds on the
// port, and each instruction's outcome is predicted from the Zicsr rules by a small model.
module tb_reindeer_csr_access_seq;

    logic        clk = 1'b0;
    logic        reset_n, sync_reset, start, abort;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_idx, rd_idx;
    logic [31:0] rs1_data;
    logic        csr_read_enable, csr_write_enable, csr_read_valid, csr_fault;
    logic [11:0] csr_read_addr, csr_write_addr;
    logic [31:0] csr_read_data, csr_write_data;
    logic        busy, done, illegal, rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reindeer_csr_access_seq #(.XLEN(32), .CSR_ADDR_BITS(12), .REG_ADDR_BITS(5)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .start(start),
        .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx), .rs1_data(rs1_data),
        .rd_idx(rd_idx), .abort(abort),
        .csr_read_enable(csr_read_enable), .csr_read_addr(csr_read_addr),
        .csr_read_valid(csr_read_valid), .csr_read_data(csr_read_data),
        .csr_write_enable(csr_write_enable), .csr_write_addr(csr_write_addr),
        .csr_write_data(csr_write_data), .csr_fault(csr_fault),
        .busy(busy), .done(done), .illegal(illegal), .rd_we(rd_we),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Behavioural CSR block: registered response, 0x7C0-0x7CF unimplemented.
    logic [31:0] csr_mem [0:4095];
    logic        preset_en = 1'b0;
    logic [11:0] preset_addr = '0;
    logic [31:0] preset_val = '0;
    logic        drop_valid = 1'b0;

    function automatic bit is_fault(input logic [11:0] a);
        return a[11:4] == 8'h7C;
    endfunction

    always @(posedge clk) begin
        csr_read_valid <= 1'b0;
        csr_fault      <= 1'b0;
        csr_read_data  <= $urandom;
        if (preset_en) csr_mem[preset_addr] <= preset_val;
        if (csr_read_enable) begin
            csr_read_valid <= !drop_valid;
            csr_read_data  <= csr_mem[csr_read_addr];
            csr_fault      <= is_fault(csr_read_addr);
        end
        if (csr_write_enable) begin
            if (!is_fault(csr_write_addr)) csr_mem[csr_write_addr] <= csr_write_data;
            csr_fault <= is_fault(csr_write_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit          ill;
        bit          rdwe;
        logic [31:0] rdd;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wdat;
        logic [31:0] fin;
    } exp_t;

    // Outcome of one instruction, straight from the Zicsr rules.
    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                                   input logic [31:0] d, input logic [4:0] rd, input logic [31:0] old,
                                   input bit drp);
        exp_t e;
        logic [31:0] src;
        bit rneed, wneed;
        e.ill = 0; e.rdwe = 0; e.rdd = 0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.wdat = 0; e.fin = old;
        src   = f3[2] ? {27'd0, idx} : d;
        rneed = !(f3[1:0] == 2'b01 && rd == 0);
        wneed = (f3[1:0] == 2'b01) || (idx != 0);
        if (f3[1:0] == 2'b00 || (wneed && a[11:10] == 2'b11)) begin
            e.ill = 1;
            return e;
        end
        e.lat = (rneed && wneed) ? 5 : 3;
        if (rneed) begin
            e.nrd = 1;
            if (is_fault(a) || drp) begin
                e.ill = 1;
                e.lat = 3;
                return e;
            end
            e.rdd = old;
        end
        if (wneed) begin
            e.nwr = 1;
            case (f3[1:0])
                2'b01:   e.wdat = src;
                2'b10:   e.wdat = old | src;
                default: e.wdat = old & ~src;
            endcase
            if (is_fault(a)) e.ill = 1;
            else e.fin = e.wdat;
        end
        e.rdwe = !e.ill && rneed && (rd != 0);
        return e;
    endfunction

    task automatic preset(input logic [11:0] a, input logic [31:0] v, input bit drp);
        @(negedge clk);
        preset_en = 1'b1; preset_addr = a; preset_val = v; drop_valid = drp;
        @(negedge clk);
        preset_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                         input logic [31:0] d, input logic [4:0] rd);
        start = 1'b1; funct3 = f3; csr_addr = a; rs1_idx = idx; rs1_data = d; rd_idx = rd;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [31:0] d, input logic [4:0] rd, input logic [31:0] old,
                          input bit drp, input bit noise);
        exp_t e;
        int lat, nrd, nwr;
        logic [31:0] wd;
        bit got;
        e = model(f3, a, idx, d, rd, old, drp);
        preset(a, old, drp);
        issue(f3, a, idx, d, rd);
        lat = 1; nrd = 0; nwr = 0; wd = 0; got = 0;
        while (lat <= 12) begin
            if (csr_read_enable) begin
                nrd++;
                chk("read_addr", {20'd0, csr_read_addr}, {20'd0, a});
            end
            if (csr_write_enable) begin
                nwr++;
                wd = csr_write_data;
                chk("write_addr", {20'd0, csr_write_addr}, {20'd0, a});
            end
            if (csr_read_enable && csr_write_enable) chk("enables_exclusive", 32'd1, 32'd0);
            if (done) begin
                got = 1;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1)); funct3 = 3'($urandom); csr_addr = 12'($urandom);
                rs1_idx = 5'($urandom); rs1_data = $urandom; rd_idx = 5'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!got) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("latency", 32'(lat), 32'(e.lat));
            chk("busy_at_done", {31'd0, busy}, 32'd1);
            chk("illegal", {31'd0, illegal}, {31'd0, e.ill});
            chk("rd_we", {31'd0, rd_we}, {31'd0, e.rdwe});
            chk("rd_addr", {27'd0, rd_addr}, {27'd0, rd});
            chk("rd_data", rd_data, e.rdd);
        end
        chk("reads_issued", 32'(nrd), 32'(e.nrd));
        chk("writes_issued", 32'(nwr), 32'(e.nwr));
        if (e.nwr != 0) chk("write_data", wd, e.wdat);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_not_busy", {31'd0, busy}, 32'd0);
        chk("rd_data_hold", rd_data, e.rdd);
        chk("csr_final", csr_mem[a], e.fin);
        drop_valid = 1'b0;
    endtask

    initial begin
        bit saw_wr, saw_done;
        logic [11:0] a;
        reset_n = 1'b0; sync_reset = 1'b0; start = 1'b0; abort = 1'b0;
        funct3 = '0; csr_addr = '0; rs1_idx = '0; rs1_data = '0; rd_idx = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_enables", {30'd0, csr_read_enable, csr_write_enable}, 32'd0);
        chk("reset_rd", {rd_we, illegal, 25'd0, rd_addr} | rd_data, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(3'b001, 12'h340, 5'd10, 32'hDEADBEEF, 5'd5, 32'h11, 0, 0);
        run_op(3'b110, 12'h300, 5'd8, 32'h0, 5'd0, 32'h1800, 0, 0);
        run_op(3'b011, 12'h305, 5'd0, 32'hFFFF_FFFF, 5'd6, 32'h8000_0100, 0, 0);
        run_op(3'b001, 12'h7C0, 5'd2, 32'h1234, 5'd1, 32'h0, 0, 0);
        run_op(3'b001, 12'hF11, 5'd2, 32'h1234, 5'd1, 32'h5, 0, 0);
        run_op(3'b000, 12'h340, 5'd2, 32'h1, 5'd3, 32'h7, 0, 0);
        run_op(3'b100, 12'h340, 5'd2, 32'h1, 5'd3, 32'h7, 0, 0);
        run_op(3'b010, 12'h340, 5'd4, 32'h30, 5'd9, 32'h3, 1, 0);
        run_op(3'b101, 12'h341, 5'd17, 32'h0, 5'd0, 32'hCAFE, 0, 0);
        run_op(3'b010, 12'hF11, 5'd0, 32'h0, 5'd3, 32'hABCD, 0, 0);

        // sync_reset during WR clears the held rd result as well
        preset(12'h340, 32'h77, 0);
        issue(3'b001, 12'h340, 5'd1, 32'h99, 5'd4);
        repeat (2) @(negedge clk);
        sync_reset = 1'b1;
        @(negedge clk);
        sync_reset = 1'b0;
        chk("sreset_busy", {31'd0, busy}, 32'd0);
        chk("sreset_rd_data", rd_data, 32'd0);
        chk("sreset_write_en", {31'd0, csr_write_enable}, 32'd0);

        // abort in RWAIT of a CSRRS: no write, no done, next op normal
        preset(12'h305, 32'h0F, 0);
        issue(3'b010, 12'h305, 5'd3, 32'hF0, 5'd7);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        saw_wr = 0; saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            saw_wr   |= csr_write_enable;
            saw_done |= done;
            @(negedge clk);
        end
        chk("abort_no_write", {31'd0, saw_wr}, 32'd0);
        chk("abort_no_done", {31'd0, saw_done}, 32'd0);
        chk("abort_csr_kept", csr_mem[12'h305], 32'h0F);
        run_op(3'b010, 12'h305, 5'd3, 32'hF0, 5'd7, 32'h0F, 0, 0);

        // abort together with start in IDLE: nothing is accepted
        start = 1'b1; abort = 1'b1; funct3 = 3'b001; csr_addr = 12'h340; rs1_idx = 5'd1; rd_idx = 5'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_ignored", {30'd0, busy, csr_read_enable}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: a = 12'h340;
                1: a = 12'h300;
                2: a = 12'h7C3;
                3: a = 12'hF11;
                4: a = 12'hC00;
                default: a = 12'($urandom);
            endcase
            run_op(3'($urandom_range(0, 7)), a,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
                   $urandom_range(0, 15) == 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
